// File: rtl/imem_fetch_unit.sv
// Instruction memory with a program-load phase (LOAD) followed by a registered
// single-cycle fetch phase (RUN). Out-of-range accesses raise a sticky fault.
module imem_fetch_unit #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       DEPTH    = 40,
    parameter int unsigned       PC_SHIFT = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_conflict,
    input  logic [15:0]       pc,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              ready,
    output logic              fault
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;

    // Storage is sized to the full index space so load_addr always indexes it directly.
    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

    logic [15:0] idx_s;
    logic        idx_oob_s;
    logic        load_oob_s;
    logic        wr_en_s;

    assign idx_s      = pc >> PC_SHIFT;
    assign idx_oob_s  = (32'(idx_s) >= DEPTH);
    assign load_oob_s = (32'(load_addr) >= DEPTH);
    assign wr_en_s    = (state_q == ST_LOAD) && load_en && !load_oob_s;

    // Program storage write port; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Next-state and next-output selection for the LOAD/RUN machine.
    always_comb begin
        state_d = state_q;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        fault_d = fault_q;
        case (state_q)
            ST_LOAD: begin
                if (load_en && load_oob_s) begin
                    fault_d = 1'b1;
                end else begin
                    fault_d = fault_q;
                end
                if (load_done) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                // Range check outranks the conflict so a bad pc is always flagged.
                if (idx_oob_s) begin
                    fault_d = 1'b1;
                end else if (mem_conflict) begin
                    instr_d = NOP_WORD;
                end else begin
                    instr_d = mem_q[idx_s[ADDR_W-1:0]];
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and all outputs registered together under the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign ready       = (state_q == ST_RUN);
    assign fault       = fault_q;

endmodule

// File: doc/imem_fetch_unit.md
IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 6, word-index width of the storage array.
REQ-003 The block SHALL have parameter DEPTH, default 40, number of valid words, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have parameter PC_SHIFT, default 2, right shift applied to pc to form the word index.
REQ-005 The block SHALL have parameter NOP_WORD, default 16'h0800, the word emitted whenever no valid instruction is available.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst as in the rest of the codebase.
REQ-007 Port clk: input, 1 bit, sole clock; all state changes on its rising edge.
REQ-008 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-009 Port mem_conflict: input, 1 bit, data side owns the memory this cycle; fetch must be suppressed.
REQ-010 Port pc: input, 16 bits, fetch address.
REQ-011 Port load_en: input, 1 bit, program-load write strobe.
REQ-012 Port load_addr: input, ADDR_W bits, program-load word index.
REQ-013 Port load_data: input, DATA_W bits, program-load word.
REQ-014 Port load_done: input, 1 bit, program image complete.
REQ-015 Port instruction: output, DATA_W bits, registered fetched word.
REQ-016 Port instr_valid: output, 1 bit, instruction holds a real fetched word.
REQ-017 Port ready: output, 1 bit, block is in RUN.
REQ-018 Port fault: output, 1 bit, sticky out-of-range fetch flag.

Function
REQ-019 The state machine SHALL have two states, LOAD and RUN; ready SHALL be 1 exactly in RUN.
REQ-020 In LOAD, with load_en=1 and load_addr < DEPTH, the block SHALL write load_data to mem[load_addr] at the rising edge.
REQ-021 A load write with load_addr >= DEPTH SHALL be dropped and SHALL set fault.
REQ-022 LOAD SHALL go to RUN on the rising edge where load_done=1; a load_en in that same cycle SHALL still be written.
REQ-023 In RUN, load_en and load_done SHALL be ignored, and RUN SHALL be left only by reset.
REQ-024 In LOAD, instruction SHALL hold NOP_WORD and instr_valid SHALL be 0 every cycle.
REQ-025 In RUN, idx = pc >> PC_SHIFT, zero-extended; no modulo or wrap is applied.
REQ-026 Fetch priority, evaluated each rising edge in RUN, SHALL be:
- (a) idx >= DEPTH: instruction=NOP_WORD, instr_valid=0, fault set.
- (b) else mem_conflict=1: instruction=NOP_WORD, instr_valid=0.
- (c) else: instruction=mem[idx], instr_valid=1.
REQ-027 Fetch latency SHALL be one cycle: pc and mem_conflict sampled at edge N appear on instruction/instr_valid after edge N.
REQ-028 There SHALL be no internal replay; after a conflict the same pc presented again SHALL fetch normally on the next edge.
REQ-029 Once set, fault SHALL stay 1 until rst.
REQ-030 A word never loaded SHALL read as undefined; verification SHALL not check its value.

Reset
REQ-031 While rst=1, asynchronously: state=LOAD, instruction=NOP_WORD, instr_valid=0, ready=0, fault=0.
REQ-032 Storage contents SHALL NOT be cleared by rst.
REQ-033 A rst asserted mid-RUN SHALL discard the current fetch and return to LOAD; reload of the program is optional.
REQ-034 The first edge after rst falls SHALL be handled as a LOAD-state edge.

Verification
REQ-035 Load: rst pulse; load mem[0]=16'h680F and mem[1]=16'h6900; load_done; pc=0 -> next cycle instruction=16'h680F, instr_valid=1; pc=4 -> 16'h6900.
REQ-036 Conflict: in RUN, pc=4 with mem_conflict=1 -> instruction=16'h0800, instr_valid=0; next cycle mem_conflict=0 -> instruction=16'h6900, instr_valid=1.
REQ-037 Range: pc=16'h00A0 (idx 40, DEPTH 40) -> NOP, instr_valid=0, fault=1; pc=0 afterwards -> valid fetch while fault stays 1.
REQ-038 Load boundary: load_en with load_addr=39 and load_done in the same cycle -> word written and ready=1 next cycle; load_addr=40 -> fault=1, no write.
REQ-039 Mid-run reset: rst during RUN -> outputs reset immediately; after release, pc=0 with load_done=1 and no reload -> previously loaded word 16'h680F returned.
REQ-040 Params: DATA_W=32, DEPTH=64, PC_SHIFT=0 -> pc=63 returns mem[63]; pc=64 -> fault=1.
